// File: rtl/muldiv_pkg.sv
// Shared types and op-decode predicates for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MADD  = 3'd4,
    MADDU = 3'd5,
    MSUB  = 3'd6,
    MSUBU = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic is_signed(input muldiv_op_t op);
    return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
  endfunction

  function automatic logic is_acc(input muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_sub(input muldiv_op_t op);
    return (op == MSUB) || (op == MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration over the 2N-bit working register, purely combinational.
// Multiply: {hi,lo} holds {partial, multiplier}; divide: {hi,lo} holds {remainder, dividend}.
// No latency and no flow control; the caller registers work_o.
module muldiv_step #(
  parameter int N_WIDTH = 32
) (
  input  logic [2*N_WIDTH-1:0] work_i,
  input  logic [N_WIDTH-1:0]   opnd_i,
  input  logic                 div_i,
  output logic [2*N_WIDTH-1:0] work_o
);

  logic [N_WIDTH:0]   sum;
  logic [N_WIDTH:0]   part;
  logic [N_WIDTH-1:0] diff;
  logic               fits;

  always_comb begin
    sum  = {1'b0, work_i[2*N_WIDTH-1:N_WIDTH]} + (work_i[0] ? {1'b0, opnd_i} : '0);
    // The remainder stays below the divisor, so the trial difference always fits N bits.
    part = {work_i[2*N_WIDTH-1:N_WIDTH], work_i[N_WIDTH-1]};
    fits = (part >= {1'b0, opnd_i});
    diff = part[N_WIDTH-1:0] - opnd_i;
    if (div_i) begin
      if (fits) work_o = {diff, work_i[N_WIDTH-2:0], 1'b1};
      else      work_o = {part[N_WIDTH-1:0], work_i[N_WIDTH-2:0], 1'b0};
    end else begin
      work_o = {sum, work_i[N_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide; MULDIV_MADD_EN adds multiply-accumulate.
// Latency: o_done N_WIDTH+2 cycles after accept, 1 cycle for divide by zero.
// Backpressure: o_ready low while busy; i_start is ignored then, i_cancel aborts.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  muldiv_op_t           i_op,
  input  logic [N_WIDTH-1:0]   i_op_a,
  input  logic [N_WIDTH-1:0]   i_op_b,
  input  logic [2*N_WIDTH-1:0] i_acc,
  input  logic                 i_cancel,
  output logic                 o_ready,
  output logic                 o_done,
  output logic [N_WIDTH-1:0]   o_hi,
  output logic [N_WIDTH-1:0]   o_lo,
  output logic                 o_div_zero
);

  localparam int CW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

  muldiv_state_t        state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  muldiv_op_t           op_q, op_in;
  logic                 neg_res_q, neg_rem_q, dz_q;
  logic [N_WIDTH-1:0]   opnd_q, hi_q, lo_q;
  logic [2*N_WIDTH-1:0] work_q, step_out, prod_s, res;
  logic [N_WIDTH-1:0]   quot_s, rem_s, a_mag, b_mag;
  logic                 a_neg, b_neg, dz_in, accept;

`ifdef MULDIV_MADD_EN
  logic [2*N_WIDTH-1:0] acc_q;
`else
  logic unused_acc;
  assign unused_acc = ^i_acc;
`endif

  always_comb begin
    op_in = i_op;
`ifndef MULDIV_MADD_EN
    if (is_acc(i_op)) op_in = is_signed(i_op) ? MULT : MULTU;
`endif
  end

  assign o_ready = (state_q == IDLE) || (state_q == DONE);
  assign accept  = i_start & o_ready & ~i_cancel;
  assign a_neg   = is_signed(op_in) & i_op_a[N_WIDTH-1];
  assign b_neg   = is_signed(op_in) & i_op_b[N_WIDTH-1];
  assign a_mag   = a_neg ? -i_op_a : i_op_a;
  assign b_mag   = b_neg ? -i_op_b : i_op_b;
  assign dz_in   = is_div(op_in) && (i_op_b == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N_WIDTH - 1)) state_d = FIX;
      end
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = dz_in ? DONE : CALC;
      cnt_d   = '0;
    end
    if (i_cancel) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  muldiv_step #(.N_WIDTH(N_WIDTH)) u_step (
    .work_i (work_q),
    .opnd_i (opnd_q),
    .div_i  (is_div(op_q)),
    .work_o (step_out)
  );

  // Overflow (most-negative / -1) wraps back to most-negative through the modular negate.
  always_comb begin
    prod_s = neg_res_q ? -work_q : work_q;
    quot_s = neg_res_q ? -work_q[N_WIDTH-1:0] : work_q[N_WIDTH-1:0];
    rem_s  = neg_rem_q ? -work_q[2*N_WIDTH-1:N_WIDTH] : work_q[2*N_WIDTH-1:N_WIDTH];
    res    = prod_s;
    if (is_div(op_q)) res = {rem_s, quot_s};
`ifdef MULDIV_MADD_EN
    else if (is_acc(op_q)) res = is_sub(op_q) ? (acc_q - prod_s) : (acc_q + prod_s);
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      work_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_MADD_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q      <= op_in;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        dz_q      <= dz_in;
        opnd_q    <= is_div(op_in) ? b_mag : a_mag;
        work_q    <= {{N_WIDTH{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
`ifdef MULDIV_MADD_EN
        acc_q     <= i_acc;
`endif
        if (dz_in) begin
          hi_q <= i_op_a;
          lo_q <= '1;
        end
      end else if (state_q == CALC) begin
        work_q <= step_out;
      end else if ((state_q == FIX) && !i_cancel) begin
        hi_q <= res[2*N_WIDTH-1:N_WIDTH];
        lo_q <= res[N_WIDTH-1:0];
      end
    end
  end

  assign o_done     = (state_q == DONE);
  assign o_hi       = hi_q;
  assign o_lo       = lo_q;
  assign o_div_zero = dz_q;

endmodule
